hsv_pipe_sched: RTL and testbench
=================================

Name: hsv_pipe_sched

Overview:
Issue controller and output buffer for the free-running, non-stallable rgb2hsv pipeline.
- Accepts an RGB pixel stream with valid/ready handshake and SOF/EOL sideband.
- Issues pixels into the pipeline and tracks them with a tag shift register matched to the pipeline latency.
- Captures H/S/V into an output FIFO, using credit accounting so the FIFO can never overflow under downstream backpressure.
- Sits between the video input interface and the HSV consumers (thresholding, histogram).

Parameters:
- LATENCY, 7, cycles from PIPE_R/G/B input to valid PIPE_H/S/V; ≥1.
- FIFO_DEPTH, 16, output FIFO entries; power of 2, ≥2.
- H_W, 25, hue width.
- SV_W, 18, saturation/value width (2.16 fixed point).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  run enable.
- IN_VALID  in  1  input pixel valid.
- IN_READY  out  1  input pixel accepted when IN_VALID & IN_READY.
- IN_R / IN_G / IN_B  in  10 each  input pixel.
- IN_SOF  in  1  first pixel of frame.
- IN_EOL  in  1  last pixel of line.
- PIPE_R / PIPE_G / PIPE_B  out  10 each  registered drive to rgb2hsv R/G/B.
- PIPE_H  in  H_W  rgb2hsv H.
- PIPE_S  in  SV_W  rgb2hsv S.
- PIPE_V  in  SV_W  rgb2hsv V.
- OUT_VALID  out  1  FIFO head valid.
- OUT_READY  in  1  consumer pop.
- OUT_H / OUT_S / OUT_V  out  H_W / SV_W / SV_W  FIFO head data.
- OUT_SOF / OUT_EOL  out  1 each  sideband aligned with head.
- BUSY  out  1  state != IDLE.
- FRAME_CNT  out  16  frames issued (SOF pixels accepted), wraps 0xFFFF→0.
- OVF  out  1  sticky; FIFO write while full (design error flag).

Behaviour:
- Reset values: state=IDLE; IN_READY=0; PIPE_R/G/B=0; tag register all 0; FIFO empty; OUT_VALID=0; OUT_H/S/V/SOF/EOL=0; BUSY=0; FRAME_CNT=0; OVF=0.
- RST mid-operation discards in-flight tags and FIFO contents. Pipeline data emerging afterwards is ignored because its tags are 0.

State machine:
- IDLE: IN_READY=0. EN=1 → RUN next cycle.
- RUN: IN_READY = (credit < FIFO_DEPTH). EN=0 → DRAIN; no issue in that same cycle (IN_READY is gated by EN combinationally).
- DRAIN: IN_READY=0. EN has no effect. When inflight==0 and FIFO empty → IDLE. EN high at that point → IDLE, then RUN on the following cycle.

Issue and tagging:
- Accept at cycle t when IN_VALID & IN_READY. PIPE_R/G/B ← IN_R/G/B at edge t+1.
- When no accept, PIPE_* hold their last value.
- Tag shift register is LATENCY+1 stages of {valid, sof, eol}. Stage 0 is loaded with {accept, IN_SOF, IN_EOL}.
- Last stage valid=1 → write {PIPE_H, PIPE_S, PIPE_V, sof, eol} into the FIFO in that cycle.
- Total latency from accept to FIFO write is LATENCY+1 cycles. With an empty FIFO, OUT_VALID rises the following cycle.

Credit accounting:
- inflight = number of set valid bits in the tag register (maintained as a counter, not a popcount).
- credit = inflight + fifo_count, range 0..FIFO_DEPTH.
- credit +1 on accept, −1 on pop (OUT_VALID & OUT_READY), unchanged when both occur in the same cycle.
- FIFO write converts inflight to fifo_count; credit is unchanged.
- Consequence: the FIFO is never written while full. If it is, set OVF and drop the write.

FIFO:
- Registered head, first-word fall-through.
- Read and write on the same cycle when full or empty are both legal: full stays full; empty+write gives OUT_VALID=1 next cycle.
- Full throughput of 1 pixel/cycle is sustained whenever OUT_READY is held high.

FRAME_CNT:
- Increments on accept with IN_SOF=1.
- Sideband is passed through unchecked; no SOF/EOL consistency enforcement.

Test Plan:
- Single pixel: RST, EN=1, one accept of R=G=B=0x3FF with SOF=1 at cycle t, model pipeline H=0, S=0, V=0x10000 → FIFO write at t+8, OUT_VALID=1 at t+9 with OUT_SOF=1, FRAME_CNT=1.
- Backpressure: OUT_READY=0, IN_VALID held high → exactly 16 accepts, then IN_READY=0. OUT_VALID stays high with 16 entries; OVF=0. Raising OUT_READY for 1 cycle → exactly one further accept.
- Streaming: IN_VALID=OUT_READY=1 for 1000 cycles with a counting pattern → 1000 outputs in order, one per cycle after the 9-cycle fill, IN_READY never drops.
- Drain: EN→0 with 5 in flight and 3 in FIFO, OUT_READY=1 → IN_READY=0 immediately, BUSY stays 1 until all 8 popped, then state IDLE and BUSY=0 next cycle.
- Reset mid-stream: RST pulsed for 1 cycle with 4 in flight and 2 in FIFO → next cycle OUT_VALID=0, credit=0, no spurious outputs over the following LATENCY+2 cycles.
- Sideband/wrap: frame of 3 lines × 4 pixels with EOL on every 4th pixel → OUT_EOL on outputs 4/8/12, single OUT_SOF; preset FRAME_CNT path wraps 0xFFFF→0 on the next SOF.

Source files
------------

// File: rtl/hsv_pipe_sched_if.sv
// Pixel stream bundle for the rgb2hsv issue controller: the RGB input
// stream with SOF/EOL sideband and the buffered HSV output stream.
interface hsv_pipe_sched_if #(
   parameter int H_W  = 25,
   parameter int SV_W = 18
);
   logic            IN_VALID;
   logic            IN_READY;
   logic [9:0]      IN_R;
   logic [9:0]      IN_G;
   logic [9:0]      IN_B;
   logic            IN_SOF;
   logic            IN_EOL;
   logic            OUT_VALID;
   logic            OUT_READY;
   logic [H_W-1:0]  OUT_H;
   logic [SV_W-1:0] OUT_S;
   logic [SV_W-1:0] OUT_V;
   logic            OUT_SOF;
   logic            OUT_EOL;

   // Video source and HSV consumer side
   modport master (
      output IN_VALID, IN_R, IN_G, IN_B, IN_SOF, IN_EOL, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_H, OUT_S, OUT_V, OUT_SOF, OUT_EOL
   );

   // Scheduler side
   modport slave (
      input  IN_VALID, IN_R, IN_G, IN_B, IN_SOF, IN_EOL, OUT_READY,
      output IN_READY, OUT_VALID, OUT_H, OUT_S, OUT_V, OUT_SOF, OUT_EOL
   );
endinterface

// File: rtl/hsv_pipe_sched.sv
// Issue controller and output buffer for the free-running rgb2hsv pipeline.
// Pixels are tagged on issue; tags ride a shift register matched to the
// pipeline latency and mark which pipeline outputs get captured into the FIFO.
// Credit (in-flight + buffered) is capped at FIFO_DEPTH so the non-stallable
// pipeline can never overrun the FIFO when the consumer stalls.
module hsv_pipe_sched #(
   parameter int LATENCY    = 7,
   parameter int FIFO_DEPTH = 16,
   parameter int H_W        = 25,
   parameter int SV_W       = 18
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   hsv_pipe_sched_if.slave   io,
   output logic [9:0]        PIPE_R,
   output logic [9:0]        PIPE_G,
   output logic [9:0]        PIPE_B,
   input  logic [H_W-1:0]    PIPE_H,
   input  logic [SV_W-1:0]   PIPE_S,
   input  logic [SV_W-1:0]   PIPE_V,
   output logic              BUSY,
   output logic [15:0]       FRAME_CNT,
   output logic              OVF
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int EW = H_W + 2 * SV_W + 2;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]     state;
   logic [1:0]     state_nxt;
   logic [CW-1:0]  credit;
   logic [CW-1:0]  inflight;
   logic [CW-1:0]  fifo_cnt;
   logic [CW-1:0]  cnt_nxt;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  rd_nxt;
   logic [LATENCY:0] tag_vld;
   logic [LATENCY:0] tag_sof;
   logic [LATENCY:0] tag_eol;
   logic [EW-1:0]  mem [FIFO_DEPTH];
   logic [EW-1:0]  wr_data;
   logic [EW-1:0]  head_q;
   logic           out_vld;
   logic           accept;
   logic           pop;
   logic           wr_req;
   logic           wr_en;
   logic           full;
   logic           drain_done;

   assign io.IN_READY = (state == ST_RUN) && EN && (credit < DEPTH_C);
   assign accept      = io.IN_VALID && io.IN_READY;
   assign pop         = out_vld && io.OUT_READY;
   assign wr_req      = tag_vld[LATENCY];
   assign full        = (fifo_cnt == DEPTH_C);
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign wr_en       = wr_req && (!full || pop);
   assign wr_data     = {PIPE_H, PIPE_S, PIPE_V, tag_sof[LATENCY], tag_eol[LATENCY]};
   assign cnt_nxt     = fifo_cnt + CW'(wr_en) - CW'(pop);
   assign rd_nxt      = rd_ptr + PW'(pop);
   // No issue happens in DRAIN, so with nothing in flight the FIFO only shrinks.
   assign drain_done  = (inflight == '0) &&
                        ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));

   assign io.OUT_VALID = out_vld;
   assign io.OUT_H     = head_q[EW-1 -: H_W];
   assign io.OUT_S     = head_q[2*SV_W+1 -: SV_W];
   assign io.OUT_V     = head_q[SV_W+1 -: SV_W];
   assign io.OUT_SOF   = head_q[1];
   assign io.OUT_EOL   = head_q[0];
   assign BUSY         = (state != ST_IDLE);

   // Next-state decode for the run/drain controller
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (EN) state_nxt = ST_RUN;
         ST_RUN:   if (!EN) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State, credit/in-flight counters, frame counter and overflow flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         credit    <= '0;
         inflight  <= '0;
         FRAME_CNT <= '0;
         OVF       <= 1'b0;
      end else begin
         state    <= state_nxt;
         credit   <= credit + CW'(accept) - CW'(pop);
         inflight <= inflight + CW'(accept) - CW'(wr_req);
         if (accept && io.IN_SOF) FRAME_CNT <= FRAME_CNT + 16'd1;
         if (wr_req && !wr_en) OVF <= 1'b1;
      end
   end

   // Issue register into the pipeline and the matching tag shift register
   always_ff @(posedge CLK) begin
      if (RST) begin
         PIPE_R  <= '0;
         PIPE_G  <= '0;
         PIPE_B  <= '0;
         tag_vld <= '0;
         tag_sof <= '0;
         tag_eol <= '0;
      end else begin
         if (accept) begin
            PIPE_R <= io.IN_R;
            PIPE_G <= io.IN_G;
            PIPE_B <= io.IN_B;
         end
         tag_vld <= {tag_vld[LATENCY-1:0], accept};
         tag_sof <= {tag_sof[LATENCY-1:0], io.IN_SOF};
         tag_eol <= {tag_eol[LATENCY-1:0], io.IN_EOL};
      end
   end

   // FIFO storage array
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // FIFO pointers, occupancy and registered fall-through head
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         out_vld  <= 1'b0;
         head_q   <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         rd_ptr   <= rd_nxt;
         fifo_cnt <= cnt_nxt;
         out_vld  <= (cnt_nxt != '0);
         if (cnt_nxt != '0)
            head_q <= (wr_en && (wr_ptr == rd_nxt)) ? wr_data : mem[rd_nxt];
      end
   end

endmodule

// File: tb/tb_hsv_pipe_sched.sv
// Directed bench for hsv_pipe_sched with a behavioural stand-in for the
// rgb2hsv pipeline (fixed latency, simple distinguishable mapping).
module tb_hsv_pipe_sched;

   localparam int LATENCY    = 7;
   localparam int FIFO_DEPTH = 16;
   localparam int H_W        = 25;
   localparam int SV_W       = 18;
   localparam int RW         = H_W + 2 * SV_W;

   logic            CLK = 1'b0;
   logic            RST;
   logic            EN;
   logic [9:0]      PIPE_R, PIPE_G, PIPE_B;
   logic [H_W-1:0]  PIPE_H;
   logic [SV_W-1:0] PIPE_S, PIPE_V;
   logic            BUSY;
   logic [15:0]     FRAME_CNT;
   logic            OVF;

   int checks = 0;
   int errors = 0;
   logic [RW-1:0] exp_v;
   logic [RW-1:0] dl [LATENCY];

   always #5 CLK = ~CLK;

   hsv_pipe_sched_if #(.H_W(H_W), .SV_W(SV_W)) bus ();

   hsv_pipe_sched #(
      .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .H_W(H_W), .SV_W(SV_W)
   ) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .io(bus),
      .PIPE_R(PIPE_R), .PIPE_G(PIPE_G), .PIPE_B(PIPE_B),
      .PIPE_H(PIPE_H), .PIPE_S(PIPE_S), .PIPE_V(PIPE_V),
      .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .OVF(OVF)
   );

   // Stand-in pipeline: gray pixels give H=S=0, white gives V=1.0 (0x10000).
   function automatic logic [RW-1:0] model(input logic [9:0] r, input logic [9:0] g,
                                           input logic [9:0] b);
      if ((r == g) && (g == b))
         return {{H_W{1'b0}}, {SV_W{1'b0}}, (r == 10'h3FF) ? 18'h10000 : {r, 8'h00}};
      return {r, g, b[9:5], 8'h00, g, b, 8'h00};
   endfunction

   always @(posedge CLK) begin
      dl[0] <= model(PIPE_R, PIPE_G, PIPE_B);
      for (int k = 1; k < LATENCY; k++) dl[k] <= dl[k-1];
   end
   assign {PIPE_H, PIPE_S, PIPE_V} = dl[LATENCY-1];

   function automatic logic [9:0] pr(input int i); return 10'(i);     endfunction
   function automatic logic [9:0] pg(input int i); return 10'(i + 3); endfunction
   function automatic logic [9:0] pb(input int i); return 10'(i * 7); endfunction
   function automatic logic [RW-1:0] pexp(input int i);
      return model(pr(i), pg(i), pb(i));
   endfunction

   task automatic set_pix(input int i);
      bus.IN_R = pr(i);
      bus.IN_G = pg(i);
      bus.IN_B = pb(i);
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      EN = 1'b0;
      bus.IN_VALID = 1'b0;
      bus.IN_SOF = 1'b0;
      bus.IN_EOL = 1'b0;
      bus.OUT_READY = 1'b0;
      bus.IN_R = '0;
      bus.IN_G = '0;
      bus.IN_B = '0;
      nxt();
      nxt();
      RST = 1'b0;
   endtask

   task automatic go_run();
      EN = 1'b1;
      nxt();
   endtask

   // Offers up to n pixels (bounded), returns how many were accepted.
   task automatic send_n(input int first_idx, input int n, output int got);
      logic a;
      got = 0;
      set_pix(first_idx);
      bus.IN_VALID = 1'b1;
      for (int c = 0; c < n + 40 && got < n; c++) begin
         @(negedge CLK);
         a = bus.IN_VALID && bus.IN_READY;
         nxt();
         if (a) begin
            got++;
            set_pix(first_idx + got);
         end
      end
      bus.IN_VALID = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      checks++;
      if ({bus.IN_READY, bus.OUT_VALID, BUSY, OVF, bus.OUT_SOF, bus.OUT_EOL} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {bus.IN_READY, bus.OUT_VALID, BUSY, OVF, bus.OUT_SOF, bus.OUT_EOL});
      end
      checks++;
      if ({PIPE_R, PIPE_G, PIPE_B} !== 30'h0) begin
         errors++;
         $display("FAIL reset_pipe: got %h expected 0", {PIPE_R, PIPE_G, PIPE_B});
      end
      checks++;
      if ({bus.OUT_H, bus.OUT_S, bus.OUT_V, FRAME_CNT} !== '0) begin
         errors++;
         $display("FAIL reset_out: got %h/%h/%h cnt %h expected 0",
                  bus.OUT_H, bus.OUT_S, bus.OUT_V, FRAME_CNT);
      end
   endtask

   task automatic test_single();
      int lat;
      do_reset();
      go_run();
      bus.IN_VALID = 1'b1;
      bus.IN_R = 10'h3FF;
      bus.IN_G = 10'h3FF;
      bus.IN_B = 10'h3FF;
      bus.IN_SOF = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.IN_READY !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: got %b expected 1", bus.IN_READY);
      end
      nxt();
      bus.IN_VALID = 1'b0;
      bus.IN_SOF = 1'b0;
      @(negedge CLK);
      checks++;
      if ({PIPE_R, PIPE_G, PIPE_B} !== {3{10'h3FF}}) begin
         errors++;
         $display("FAIL single_pipe_drive: got %h expected 3fffffff", {PIPE_R, PIPE_G, PIPE_B});
      end
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         nxt();
         @(negedge CLK);
         if (bus.OUT_VALID) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL single_latency: got %0d edges expected 8 after accept edge", lat);
      end
      checks++;
      if ({bus.OUT_H, bus.OUT_S, bus.OUT_V} !== {25'h0, 18'h0, 18'h10000}) begin
         errors++;
         $display("FAIL single_data: got %h/%h/%h expected 0/0/10000",
                  bus.OUT_H, bus.OUT_S, bus.OUT_V);
      end
      checks++;
      if ({bus.OUT_SOF, bus.OUT_EOL, FRAME_CNT} !== {1'b1, 1'b0, 16'd1}) begin
         errors++;
         $display("FAIL single_sideband: got sof %b eol %b cnt %0d expected 1 0 1",
                  bus.OUT_SOF, bus.OUT_EOL, FRAME_CNT);
      end
      nxt();
      bus.OUT_READY = 1'b1;
      nxt();
      bus.OUT_READY = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin
         errors++;
         $display("FAIL single_pop_empty: got %b expected 0", bus.OUT_VALID);
      end
   endtask

   task automatic test_backpressure();
      int got;
      do_reset();
      go_run();
      send_n(0, 40, got);
      checks++;
      if (got != FIFO_DEPTH) begin
         errors++;
         $display("FAIL bp_accepts: got %0d expected %0d", got, FIFO_DEPTH);
      end
      bus.IN_VALID = 1'b1;
      repeat (12) nxt();
      @(negedge CLK);
      checks++;
      if ({bus.IN_READY, bus.OUT_VALID, OVF} !== 3'b010) begin
         errors++;
         $display("FAIL bp_full_state: got rdy %b vld %b ovf %b expected 0 1 0",
                  bus.IN_READY, bus.OUT_VALID, OVF);
      end
      exp_v = pexp(0);
      checks++;
      if ({bus.OUT_H, bus.OUT_S, bus.OUT_V} !== exp_v) begin
         errors++;
         $display("FAIL bp_head0: got %h expected %h", {bus.OUT_H, bus.OUT_S, bus.OUT_V}, exp_v);
      end
      nxt();
      bus.OUT_READY = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.IN_READY !== 1'b0) begin
         errors++;
         $display("FAIL bp_pop_cycle_ready: got %b expected 0", bus.IN_READY);
      end
      nxt();
      bus.OUT_READY = 1'b0;
      send_n(16, 10, got);
      checks++;
      if (got != 1) begin
         errors++;
         $display("FAIL bp_extra_accept: got %0d expected 1", got);
      end
      @(negedge CLK);
      exp_v = pexp(1);
      checks++;
      if ({bus.OUT_H, bus.OUT_S, bus.OUT_V} !== exp_v) begin
         errors++;
         $display("FAIL bp_head1: got %h expected %h", {bus.OUT_H, bus.OUT_S, bus.OUT_V}, exp_v);
      end
   endtask

   task automatic test_streaming();
      int sent, rcv, first, drops, late;
      logic a;
      do_reset();
      go_run();
      bus.OUT_READY = 1'b1;
      sent = 0; rcv = 0; first = -1; drops = 0; late = 0;
      set_pix(0);
      bus.IN_VALID = 1'b1;
      for (int c = 0; c < 1200 && rcv < 1000; c++) begin
         @(negedge CLK);
         if (bus.IN_VALID && !bus.IN_READY) drops++;
         a = bus.IN_VALID && bus.IN_READY;
         if (a && first < 0) first = c;
         if (bus.OUT_VALID) begin
            exp_v = pexp(rcv);
            checks++;
            if ({bus.OUT_H, bus.OUT_S, bus.OUT_V} !== exp_v) begin
               errors++;
               $display("FAIL stream_data[%0d]: got %h expected %h", rcv,
                        {bus.OUT_H, bus.OUT_S, bus.OUT_V}, exp_v);
            end
            if (c != first + 9 + rcv) late++;
            rcv++;
         end
         nxt();
         if (a) begin
            sent++;
            if (sent == 1000) bus.IN_VALID = 1'b0;
            else set_pix(sent);
         end
      end
      checks++;
      if (rcv != 1000) begin
         errors++;
         $display("FAIL stream_count: got %0d expected 1000", rcv);
      end
      checks++;
      if (drops != 0) begin
         errors++;
         $display("FAIL stream_ready_drop: got %0d expected 0", drops);
      end
      checks++;
      if (late != 0) begin
         errors++;
         $display("FAIL stream_timing: got %0d off-slot outputs expected 0", late);
      end
   endtask

   task automatic test_drain();
      int got, pops, busy_bad, rdy_bad, order_bad;
      do_reset();
      go_run();
      send_n(0, 3, got);
      repeat (10) nxt();
      send_n(3, 5, got);
      EN = 1'b0;
      bus.OUT_READY = 1'b1;
      bus.IN_VALID = 1'b1;
      set_pix(100);
      @(negedge CLK);
      checks++;
      if ({bus.IN_READY, BUSY} !== 2'b01) begin
         errors++;
         $display("FAIL drain_enter: got rdy %b busy %b expected 0 1", bus.IN_READY, BUSY);
      end
      pops = 0; busy_bad = 0; rdy_bad = 0; order_bad = 0;
      for (int c = 0; c < 60 && pops < 8; c++) begin
         if (bus.IN_READY) rdy_bad++;
         if (!BUSY) busy_bad++;
         if (bus.OUT_VALID) begin
            exp_v = pexp(pops);
            if ({bus.OUT_H, bus.OUT_S, bus.OUT_V} !== exp_v) order_bad++;
            pops++;
         end
         nxt();
         @(negedge CLK);
      end
      bus.IN_VALID = 1'b0;
      checks++;
      if ({pops, busy_bad, rdy_bad, order_bad} !== {32'd8, 32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL drain_pops: got pops %0d busy_low %0d rdy %0d order %0d expected 8 0 0 0",
                  pops, busy_bad, rdy_bad, order_bad);
      end
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("FAIL drain_idle: got busy %b expected 0", BUSY);
      end
   endtask

   task automatic test_reset_mid();
      int got, spurious;
      do_reset();
      go_run();
      send_n(0, 2, got);
      repeat (10) nxt();
      send_n(2, 4, got);
      RST = 1'b1;
      nxt();
      RST = 1'b0;
      @(negedge CLK);
      checks++;
      if ({bus.OUT_VALID, BUSY, bus.IN_READY} !== 3'b000) begin
         errors++;
         $display("FAIL rstmid_flush: got vld %b busy %b rdy %b expected 0 0 0",
                  bus.OUT_VALID, BUSY, bus.IN_READY);
      end
      spurious = 0;
      for (int c = 0; c < LATENCY + 2; c++) begin
         nxt();
         @(negedge CLK);
         if (bus.OUT_VALID) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL rstmid_spurious: got %0d expected 0", spurious);
      end
      nxt();
      send_n(50, 20, got);
      checks++;
      if (got != FIFO_DEPTH) begin
         errors++;
         $display("FAIL rstmid_credit: got %0d accepts expected %0d", got, FIFO_DEPTH);
      end
   endtask

   task automatic test_sideband();
      int k, rcv;
      logic a;
      logic [11:0] sof_m, eol_m;
      do_reset();
      go_run();
      bus.OUT_READY = 1'b1;
      k = 0; rcv = 0; sof_m = '0; eol_m = '0;
      set_pix(0);
      bus.IN_SOF = 1'b1;
      bus.IN_EOL = 1'b0;
      bus.IN_VALID = 1'b1;
      for (int c = 0; c < 80 && rcv < 12; c++) begin
         @(negedge CLK);
         a = bus.IN_VALID && bus.IN_READY;
         if (bus.OUT_VALID) begin
            sof_m[rcv[3:0]] = bus.OUT_SOF;
            eol_m[rcv[3:0]] = bus.OUT_EOL;
            rcv++;
         end
         nxt();
         if (a) begin
            k++;
            if (k == 12) begin
               bus.IN_VALID = 1'b0;
               bus.IN_SOF = 1'b0;
               bus.IN_EOL = 1'b0;
            end else begin
               set_pix(k);
               bus.IN_SOF = 1'b0;
               bus.IN_EOL = ((k % 4) == 3);
            end
         end
      end
      checks++;
      if (rcv != 12) begin
         errors++;
         $display("FAIL side_count: got %0d expected 12", rcv);
      end
      checks++;
      if (eol_m !== 12'h888) begin
         errors++;
         $display("FAIL side_eol: got %h expected 888", eol_m);
      end
      checks++;
      if (sof_m !== 12'h001) begin
         errors++;
         $display("FAIL side_sof: got %h expected 001", sof_m);
      end
      checks++;
      if (FRAME_CNT !== 16'd1) begin
         errors++;
         $display("FAIL side_frame_cnt: got %0d expected 1", FRAME_CNT);
      end
   endtask

   task automatic test_frame_wrap();
      int got;
      do_reset();
      go_run();
      bus.OUT_READY = 1'b1;
      bus.IN_SOF = 1'b1;
      send_n(0, 65535, got);
      @(negedge CLK);
      checks++;
      if (FRAME_CNT !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_max: got %h expected ffff", FRAME_CNT);
      end
      nxt();
      send_n(0, 1, got);
      bus.IN_SOF = 1'b0;
      @(negedge CLK);
      checks++;
      if (FRAME_CNT !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_zero: got %h expected 0000", FRAME_CNT);
      end
      checks++;
      if (OVF !== 1'b0) begin
         errors++;
         $display("FAIL wrap_ovf: got %b expected 0", OVF);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_streaming();
      test_drain();
      test_reset_mid();
      test_sideband();
      test_frame_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
